// File: rtl/sreg_stream_source.sv
// sreg_stream_source: back-pressure-aware reader for a registered signed datapath stage.
// Words arrive over a valid/ready handshake and leave sign-extended over a second
// valid/ready handshake. A main output register plus one skid register give full
// throughput, and d_ready never depends combinationally on q_ready.
module sreg_stream_source #(
    parameter int DATAWIDTH = 2,
    parameter int OUT_WIDTH = 2
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic signed [DATAWIDTH-1:0] d,
    input  logic                        d_valid,
    output logic                        d_ready,
    output logic signed [OUT_WIDTH-1:0] q,
    output logic                        q_valid,
    input  logic                        q_ready,
    output logic [1:0]                  count
);

    // The state encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                      state_q;
    logic signed [OUT_WIDTH-1:0] out_q;
    logic signed [OUT_WIDTH-1:0] skid_q;
    logic                        accept;
    logic                        pop;

    // Two's-complement widening; a signed size cast replicates the sign bit
    // and degenerates to a plain copy when the widths match.
    function automatic logic signed [OUT_WIDTH-1:0] sext(input logic signed [DATAWIDTH-1:0] v);
        return OUT_WIDTH'(v);
    endfunction

    // Handshake decode: d_ready looks only at state and reset, q_valid only at state.
    always_comb begin
        d_ready = !Rst && (state_q != FULL);
        q_valid = (state_q != EMPTY);
        accept  = d_valid && d_ready;
        pop     = q_valid && q_ready;
        q       = out_q;
        count   = state_q;
    end

    // Occupancy FSM with its data registers; reset clears data too so q reads zero.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= BUSY;
                        out_q   <= sext(d);
                    end
                end
                BUSY: begin
                    case ({accept, pop})
                        2'b11: out_q <= sext(d);
                        2'b10: begin
                            state_q <= FULL;
                            skid_q  <= sext(d);
                        end
                        2'b01: state_q <= EMPTY;
                        default: ;
                    endcase
                end
                FULL: begin
                    // No accept is possible here since d_ready is low.
                    if (pop) begin
                        state_q <= BUSY;
                        out_q   <= skid_q;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_sreg_stream_source.sv
// Directed bench for sreg_stream_source with DATAWIDTH=4, OUT_WIDTH=8.
module tb_sreg_stream_source;

    logic       clk;
    logic       rst;
    logic [3:0] d;
    logic       d_valid;
    logic       d_ready;
    logic [7:0] q;
    logic       q_valid;
    logic       q_ready;
    logic [1:0] count;

    int n_chk  = 0;
    int n_pass = 0;

    sreg_stream_source #(
        .DATAWIDTH(4),
        .OUT_WIDTH(8)
    ) dut (
        .Clk     (clk),
        .Rst     (rst),
        .d       (d),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .q       (q),
        .q_valid (q_valid),
        .q_ready (q_ready),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] v;
        logic [7:0] e;

        // Reset with a word offered: it must be discarded.
        rst = 1'b1; d_valid = 1'b1; d = 4'h7; q_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_q", q, 8'h00);
            chk("rst_qv", q_valid, 1'b0);
            chk("rst_dr", d_ready, 1'b0);
            chk("rst_cnt", count, 2'd0);
        end
        rst = 1'b0; d_valid = 1'b0;
        step();
        chk("post_rst_dr", d_ready, 1'b1);
        chk("post_rst_cnt", count, 2'd0);

        // Single negative word, sign extended.
        d = 4'b1010; d_valid = 1'b1;
        step();
        d_valid = 1'b0;
        chk("single_q", q, 8'hFA);
        chk("single_qv", q_valid, 1'b1);
        chk("single_cnt", count, 2'd1);
        q_ready = 1'b1;
        step();
        chk("single_pop_qv", q_valid, 1'b0);
        chk("single_pop_cnt", count, 2'd0);
        q_ready = 1'b0;

        // Back-pressure fill, refused third push, then drain in order.
        d = 4'h3; d_valid = 1'b1;
        step();
        chk("fill1_cnt", count, 2'd1);
        chk("fill1_q", q, 8'h03);
        chk("fill1_dr", d_ready, 1'b1);
        d = 4'h5;
        step();
        chk("fill2_cnt", count, 2'd2);
        chk("fill2_dr", d_ready, 1'b0);
        chk("fill2_q", q, 8'h03);
        d = 4'h7;
        step();
        chk("fill3_cnt", count, 2'd2);
        chk("fill3_q", q, 8'h03);
        d_valid = 1'b0; q_ready = 1'b1;
        chk("drain0_q", q, 8'h03);
        step();
        chk("drain1_q", q, 8'h05);
        chk("drain1_cnt", count, 2'd1);
        step();
        chk("drain2_cnt", count, 2'd0);
        chk("drain2_qv", q_valid, 1'b0);

        // Streaming 0..15 at one word per cycle.
        d_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v = i[3:0];
            d = v;
            step();
            e = {{4{v[3]}}, v};
            chk("stream_q", q, e);
            chk("stream_cnt", count, 2'd1);
            chk("stream_dr", d_ready, 1'b1);
        end
        d_valid = 1'b0;
        step();
        chk("stream_end_cnt", count, 2'd0);

        // Accept and pop on the same edge while BUSY.
        q_ready = 1'b0; d = 4'h2; d_valid = 1'b1;
        step();
        chk("sim_pre_q", q, 8'h02);
        d = 4'h9; q_ready = 1'b1;
        step();
        chk("sim_q", q, 8'hF9);
        chk("sim_cnt", count, 2'd1);
        d_valid = 1'b0;
        step();
        chk("sim_after_cnt", count, 2'd0);

        // Reset while FULL, then confirm no stale word survives.
        q_ready = 1'b0; d = 4'h1; d_valid = 1'b1;
        step();
        d = 4'h4;
        step();
        chk("mid_full_cnt", count, 2'd2);
        chk("mid_full_q", q, 8'h01);
        rst = 1'b1;
        chk("mid_rst_dr", d_ready, 1'b0);
        step();
        rst = 1'b0;
        chk("mid_rst_cnt", count, 2'd0);
        chk("mid_rst_qv", q_valid, 1'b0);
        chk("mid_rst_q", q, 8'h00);
        d = 4'h6; d_valid = 1'b1;
        step();
        d_valid = 1'b0;
        chk("mid_push_q", q, 8'h06);
        chk("mid_push_cnt", count, 2'd1);
        q_ready = 1'b1;
        step();
        chk("mid_pop_cnt", count, 2'd0);
        chk("mid_pop_qv", q_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
